dmux_way_bank: RTL and testbench

//   Registered dual demultiplexer: one data input is steered to 1 of 4 outputs
//   (4-way bank) and, in parallel, to 1 of 8 outputs (8-way bank).
//   Non-selected outputs are driven to 0.

---
 rtl/dmux_way_bank.sv | 65 ++++++
 tb/tb_dmux_way_bank.sv | 113 +++++++++++
 2 files changed

// File: rtl/dmux_way_bank.sv
// Registered dual demultiplexer: one data word is steered to 1 of 4 outputs
// (sel[1:0]) and, in parallel, to 1 of 8 outputs (sel[2:0]). All other outputs are zero.
module dmux_way_bank #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] a4,
    output logic [WIDTH-1:0] b4,
    output logic [WIDTH-1:0] c4,
    output logic [WIDTH-1:0] d4,
    output logic [WIDTH-1:0] a8,
    output logic [WIDTH-1:0] b8,
    output logic [WIDTH-1:0] c8,
    output logic [WIDTH-1:0] d8,
    output logic [WIDTH-1:0] e8,
    output logic [WIDTH-1:0] f8,
    output logic [WIDTH-1:0] g8,
    output logic [WIDTH-1:0] h8
);

    logic [3:0][WIDTH-1:0] bank4_q, bank4_d;
    logic [7:0][WIDTH-1:0] bank8_q, bank8_d;

    always_comb begin
        bank4_d = bank4_q;
        bank8_d = bank8_q;
        if (en) begin
            // sel[2] plays no part in the 4-way decode
            for (int unsigned i = 0; i < 4; i++) begin
                bank4_d[i] = (sel[1:0] == 2'(i)) ? in : '0;
            end
            for (int unsigned i = 0; i < 8; i++) begin
                bank8_d[i] = (sel == 3'(i)) ? in : '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bank4_q <= '0;
            bank8_q <= '0;
        end else begin
            bank4_q <= bank4_d;
            bank8_q <= bank8_d;
        end
    end

    assign a4 = bank4_q[0];
    assign b4 = bank4_q[1];
    assign c4 = bank4_q[2];
    assign d4 = bank4_q[3];
    assign a8 = bank8_q[0];
    assign b8 = bank8_q[1];
    assign c8 = bank8_q[2];
    assign d8 = bank8_q[3];
    assign e8 = bank8_q[4];
    assign f8 = bank8_q[5];
    assign g8 = bank8_q[6];
    assign h8 = bank8_q[7];

endmodule

// File: tb/tb_dmux_way_bank.sv
// Scoreboard bench for dmux_way_bank: directed cases then random traffic,
// expected outputs from an array-based reference model.
module tb_dmux_way_bank;

    localparam int unsigned W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         en    = 1'b0;
    logic [W-1:0] in    = '0;
    logic [2:0]   sel   = '0;
    logic [W-1:0] a4, b4, c4, d4, a8, b8, c8, d8, e8, f8, g8, h8;

    dmux_way_bank #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .en(en), .in(in), .sel(sel),
        .a4(a4), .b4(b4), .c4(c4), .d4(d4),
        .a8(a8), .b8(b8), .c8(c8), .d8(d8),
        .e8(e8), .f8(f8), .g8(g8), .h8(h8)
    );

    always #5 clock = ~clock;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [W-1:0] m4 [4];
    logic [W-1:0] m8 [8];
    bit           model_valid = 1'b0;
    logic [12*W-1:0] exp_q [$];
    string           name_q [$];

    function automatic logic [12*W-1:0] dut_vec();
        return {a4, b4, c4, d4, a8, b8, c8, d8, e8, f8, g8, h8};
    endfunction

    function automatic logic [12*W-1:0] model_vec();
        logic [12*W-1:0] v;
        v = {m4[0], m4[1], m4[2], m4[3],
             m8[0], m8[1], m8[2], m8[3], m8[4], m8[5], m8[6], m8[7]};
        return v;
    endfunction

    task automatic compare(input string name, input logic [12*W-1:0] act,
                           input logic [12*W-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check that outputs have
    // not moved yet, then advance the model and queue its post-edge state.
    task automatic step(input bit r, input bit e, input logic [2:0] s,
                        input logic [W-1:0] d, input string name);
        reset = r;
        en    = e;
        sel   = s;
        in    = d;
        #1;
        if (model_valid) compare({name, "_hold_pre_edge"}, dut_vec(), model_vec());
        if (r) begin
            for (int i = 0; i < 4; i++) m4[i] = '0;
            for (int i = 0; i < 8; i++) m8[i] = '0;
        end else if (e) begin
            for (int i = 0; i < 4; i++) m4[i] = (i == int'(s) % 4) ? d : '0;
            for (int i = 0; i < 8; i++) m8[i] = (i == int'(s)) ? d : '0;
        end
        if (r) model_valid = 1'b1;
        if (model_valid) begin
            exp_q.push_back(model_vec());
            name_q.push_back(name);
        end
        @(negedge clock);
    endtask

    // Monitor: every rising edge presents a new output word.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) compare(name_q.pop_front(), dut_vec(), exp_q.pop_front());
        end
    end

    initial begin
        logic [2:0] rs;
        step(1'b1, 1'b1, 3'd3, 8'h01, "reset");
        for (int s = 0; s < 8; s++) step(1'b0, 1'b1, 3'(s), 8'h00, "zero_sweep");
        for (int s = 0; s < 8; s++) step(1'b0, 1'b1, 3'(s), 8'h01, "one_sweep");
        step(1'b0, 1'b1, 3'd2, 8'h01, "hold_setup");
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'd6, 8'h00, "hold");
        step(1'b0, 1'b1, 3'd3, 8'h01, "latency_sel3");
        step(1'b0, 1'b1, 3'd6, 8'h01, "latency_sel6");
        step(1'b1, 1'b1, 3'd7, 8'hA5, "reset_priority");
        step(1'b0, 1'b1, 3'd7, 8'hA5, "post_reset_update");
        step(1'b0, 1'b1, 3'd5, 8'hFF, "full_width");
        for (int k = 0; k < 300; k++) begin
            rs = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 rs, W'($urandom), "random");
        end
        repeat (2) @(negedge clock);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
